// File: rtl/operand_fetch_if.sv
// Handshake, operand-bundle and writeback signals between decode, operand fetch and the ALU stage.
// The master modport is the environment side; the slave modport is the operand_fetch block.
interface operand_fetch_if #(
   parameter int W   = 8,
   parameter int OPW = 3
);
   logic           InValid;
   logic           InReady;
   logic [OPW-1:0] InOp;
   logic [2:0]     InRa;
   logic [2:0]     InRb;
   logic [2:0]     InRd;
   logic           InImmSel;
   logic [W-1:0]   InImm;

   logic           WbEn;
   logic [2:0]     WbAddr;
   logic [W-1:0]   WbData;

   logic           OutValid;
   logic           OutReady;
   logic [W-1:0]   InputA;
   logic [W-1:0]   InputB;
   logic [OPW-1:0] OP;
   logic [2:0]     OutRd;

   modport master (
      output InValid, InOp, InRa, InRb, InRd, InImmSel, InImm,
      output WbEn, WbAddr, WbData,
      output OutReady,
      input  InReady, OutValid, InputA, InputB, OP, OutRd
   );

   modport slave (
      input  InValid, InOp, InRa, InRb, InRd, InImmSel, InImm,
      input  WbEn, WbAddr, WbData,
      input  OutReady,
      output InReady, OutValid, InputA, InputB, OP, OutRd
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: 8-entry register file with same-cycle writeback bypass, feeding a
// one-deep registered operand bundle to the ALU through a valid/ready handshake.
module operand_fetch #(
   parameter int W   = 8,
   parameter int OPW = 3
) (
   input logic              Clk,
   input logic              Reset_n,
   operand_fetch_if.slave   bus
);

   logic [W-1:0]   regfile [8];
   logic [W-1:0]   rda;
   logic [W-1:0]   rdb;
   logic [W-1:0]   opb;
   logic           accept;

   logic           outvalid;
   logic [W-1:0]   inputa;
   logic [W-1:0]   inputb;
   logic [OPW-1:0] op;
   logic [2:0]     outrd;

   // A writeback landing this cycle is visible to the instruction being accepted this cycle.
   always_comb begin
      rda = regfile[bus.InRa];
      rdb = regfile[bus.InRb];
      if (bus.WbEn && (bus.WbAddr == bus.InRa)) begin
         rda = bus.WbData;
      end
      if (bus.WbEn && (bus.WbAddr == bus.InRb)) begin
         rdb = bus.WbData;
      end
      opb = bus.InImmSel ? bus.InImm : rdb;
   end

   assign bus.InReady = !outvalid || bus.OutReady;
   assign accept      = bus.InValid && bus.InReady;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 8; i++) begin
            regfile[i] <= '0;
         end
      end else if (bus.WbEn) begin
         regfile[bus.WbAddr] <= bus.WbData;
      end
   end

   // Operands are captured at accept, so later writebacks never disturb a stalled bundle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         outvalid <= 1'b0;
         inputa   <= '0;
         inputb   <= '0;
         op       <= '0;
         outrd    <= '0;
      end else if (accept) begin
         outvalid <= 1'b1;
         inputa   <= rda;
         inputb   <= opb;
         op       <= bus.InOp;
         outrd    <= bus.InRd;
      end else if (bus.OutReady) begin
         outvalid <= 1'b0;
      end
   end

   assign bus.OutValid = outvalid;
   assign bus.InputA   = inputa;
   assign bus.InputB   = inputb;
   assign bus.OP       = op;
   assign bus.OutRd    = outrd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the register file and the single outstanding bundle.
module tb_operand_fetch;

   localparam int W   = 8;
   localparam int OPW = 3;

   logic Clk;
   logic Reset_n;
   int   checkCount;
   int   errorCount;

   operand_fetch_if #(.W(W), .OPW(OPW)) bus ();

   operand_fetch #(.W(W), .OPW(OPW)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference state: architectural registers and the bundle the ALU currently sees.
   logic [W-1:0]   mRegs [8];
   bit             mValid;
   logic [W-1:0]   mA;
   logic [W-1:0]   mB;
   logic [OPW-1:0] mOp;
   logic [2:0]     mRd;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic inValid, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [2:0] rd, input logic [OPW-1:0] op, input logic immSel,
                                input logic [W-1:0] imm, input logic wbEn, input logic [2:0] wbAddr,
                                input logic [W-1:0] wbData, input logic outReady);
      bus.InValid  = inValid;
      bus.InRa     = ra;
      bus.InRb     = rb;
      bus.InRd     = rd;
      bus.InOp     = op;
      bus.InImmSel = immSel;
      bus.InImm    = imm;
      bus.WbEn     = wbEn;
      bus.WbAddr   = wbAddr;
      bus.WbData   = wbData;
      bus.OutReady = outReady;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) mRegs[i] = '0;
      mValid = 1'b0;
      mA     = '0;
      mB     = '0;
      mOp    = '0;
      mRd    = '0;
   endtask

   task automatic checkBundle(input string tag);
      checkOutput({tag, ".OutValid"}, bus.OutValid, mValid);
      checkOutput({tag, ".InputA"}, bus.InputA, mA);
      checkOutput({tag, ".InputB"}, bus.InputB, mB);
      checkOutput({tag, ".OP"}, bus.OP, mOp);
      checkOutput({tag, ".OutRd"}, bus.OutRd, mRd);
   endtask

   // One clock of traffic: predict readiness and the next bundle from the inputs already driven.
   task automatic stepCycle(input string tag);
      logic [W-1:0]   nr [8];
      logic [W-1:0]   nA;
      logic [W-1:0]   nB;
      logic [OPW-1:0] nOp;
      logic [2:0]     nRd;
      bit             expReady;
      bit             acc;
      bit             consumed;
      #1;
      expReady = !mValid || bus.OutReady;
      checkOutput({tag, ".InReady"}, bus.InReady, expReady);
      for (int i = 0; i < 8; i++) nr[i] = mRegs[i];
      if (bus.WbEn) nr[bus.WbAddr] = bus.WbData;
      acc      = bus.InValid && expReady;
      consumed = mValid && bus.OutReady;
      nA  = nr[bus.InRa];
      nB  = bus.InImmSel ? bus.InImm : nr[bus.InRb];
      nOp = bus.InOp;
      nRd = bus.InRd;
      @(posedge Clk);
      #1;
      if (acc) begin
         mValid = 1'b1;
         mA     = nA;
         mB     = nB;
         mOp    = nOp;
         mRd    = nRd;
      end else if (consumed) begin
         mValid = 1'b0;
      end
      for (int i = 0; i < 8; i++) mRegs[i] = nr[i];
      checkBundle(tag);
   endtask

   initial begin
      logic [W-1:0] heldA;
      checkCount = 0;
      errorCount = 0;
      modelReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      Reset_n = 1'b0;
      #2;
      checkBundle("reset");
      checkOutput("reset.InReady", bus.InReady, 1);
      @(posedge Clk);
      #1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 8'hEE, 1);
      @(negedge Clk);
      Reset_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Untouched registers read as zero on the first accept after reset.
      applyStimulus(1, 3'd1, 3'd2, 3'd0, 3'b000, 0, 8'h00, 0, 0, 0, 1);
      stepCycle("first");
      checkOutput("first.valid", bus.OutValid, 1);
      checkOutput("first.a", bus.InputA, 8'h00);
      checkOutput("first.b", bus.InputB, 8'h00);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd3, 8'h5A, 1);
      stepCycle("wr3");
      applyStimulus(1, 3'd3, 3'd0, 3'd1, 3'd2, 1, 8'h0F, 0, 0, 0, 1);
      stepCycle("imm");
      checkOutput("imm.a", bus.InputA, 8'h5A);
      checkOutput("imm.b", bus.InputB, 8'h0F);

      applyStimulus(1, 3'd4, 3'd4, 3'd2, 3'd5, 0, 8'h00, 1, 3'd4, 8'hC3, 1);
      stepCycle("bypass");
      checkOutput("bypass.a", bus.InputA, 8'hC3);
      checkOutput("bypass.b", bus.InputB, 8'hC3);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3'd5, 8'h11, 1);
      stepCycle("wr5");
      applyStimulus(1, 3'd5, 3'd1, 3'd6, 3'd1, 0, 8'h00, 0, 0, 0, 1);
      stepCycle("load5");
      checkOutput("load5.a", bus.InputA, 8'h11);

      // Three stalled cycles with a pending instruction and a writeback into the held source.
      heldA = bus.InputA;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 3'd5, 3'd3, 3'd7, 3'd6, 0, 8'h00, (i == 0), 3'd5, 8'h22, 0);
         stepCycle("stall");
         checkOutput("stall.ready", bus.InReady, 0);
         checkOutput("stall.hold", bus.InputA, heldA);
         checkOutput("stall.a", bus.InputA, 8'h11);
      end
      applyStimulus(1, 3'd5, 3'd3, 3'd7, 3'd6, 0, 8'h00, 0, 0, 0, 1);
      stepCycle("release");
      checkOutput("release.valid", bus.OutValid, 1);
      checkOutput("release.a", bus.InputA, 8'h22);
      checkOutput("release.rd", bus.OutRd, 3'd7);

      applyStimulus(1, 3'd3, 3'd4, 3'd1, 3'd3, 0, 8'h00, 0, 0, 0, 0);
      stepCycle("prestall");
      Reset_n = 1'b0;
      #1;
      modelReset();
      checkBundle("midreset");
      applyStimulus(1, 3'd3, 3'd4, 3'd1, 3'd3, 0, 8'h00, 1, 3'd6, 8'h77, 1);
      @(posedge Clk);
      #1;
      checkOutput("midreset.held", bus.OutValid, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 3'(i), 3'(i), 3'(i), 3'd0, 0, 8'h00, 0, 0, 0, 1);
         stepCycle("cleared");
         checkOutput("cleared.a", bus.InputA, 8'h00);
      end

      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom),
                       OPW'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
                       1'($urandom_range(0, 1)), 3'($urandom), W'($urandom),
                       ($urandom_range(0, 3) != 0));
         stepCycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named Clk and Reset_n.
REQ-002 Parameter W, default 8: datapath width in bits.
REQ-003 Parameter OPW, default 3: operation-code width in bits.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 InValid  input  1  a decoded instruction is present on the In* ports.
REQ-007 InReady  output  1  the block accepts the presented instruction this cycle.
REQ-008 InOp  input  OPW  operation code, passed through to OP.
REQ-009 InRa, InRb, InRd  input  3 each  source A, source B and destination register indices.
REQ-010 InImmSel  input  1  selects InImm instead of register Rb as operand B.
REQ-011 InImm  input  W  immediate operand.
REQ-012 WbEn, WbAddr, WbData  input  1/3/W  register writeback port from the downstream stage.
REQ-013 OutValid  output  1  InputA, InputB, OP and OutRd hold a valid operand bundle.
REQ-014 OutReady  input  1  the downstream ALU stage consumes the bundle this cycle.
REQ-015 InputA, InputB  output  W each  registered operands driven to the ALU.
REQ-016 OP  output  OPW  registered operation code driven to the ALU.
REQ-017 OutRd  output  3  registered destination index, carried to writeback.

Function
REQ-018 The block SHALL contain a register file of 8 entries, each W bits wide; every entry is writable, including entry 0.
REQ-019 On a rising Clk edge with WbEn=1, the block SHALL write WbData to entry WbAddr.
REQ-020 Reads SHALL be combinational, with same-cycle bypass: when WbEn=1 and WbAddr equals the read index, the read value is WbData.
REQ-021 Operand A SHALL be the bypassed read of InRa.
REQ-022 Operand B SHALL be InImm when InImmSel=1; otherwise it SHALL be the bypassed read of InRb.
REQ-023 InReady SHALL equal (!OutValid || OutReady), combinationally.
REQ-024 An accept SHALL occur when InValid && InReady at a rising edge; the block then registers the operands, InOp and InRd onto the outputs and sets OutValid=1.
REQ-025 Latency SHALL be one cycle from accept to OutValid=1; back-to-back accepts SHALL sustain one bundle per cycle while OutReady=1.
REQ-026 When OutValid=1 and OutReady=1 with no accept, OutValid SHALL clear on that edge.
REQ-027 When OutValid=1 and OutReady=0, InputA, InputB, OP and OutRd SHALL hold stable, and no accept SHALL occur.
REQ-028 A writeback to a register that a held bundle read SHALL NOT change the held outputs, because operands are captured at accept.
REQ-029 When OutValid=0, the output data values are don't-care, but they SHALL change only on an accept.
REQ-030 A simultaneous accept and writeback SHALL both take effect, and the accepted bundle SHALL see the new value through the bypass.
REQ-031 Index arithmetic SHALL be 3-bit unsigned with no wrap beyond 7; all data paths SHALL be exactly W bits with no extension.

Reset
REQ-032 While Reset_n=0, the block SHALL immediately clear all 8 register entries to 0, OutValid to 0, and InputA, InputB, OP and OutRd to 0.
REQ-033 While Reset_n=0, writeback and accept SHALL be ignored; a bundle held when reset asserts mid-operation SHALL be discarded.
REQ-034 On the first edge after Reset_n rises, the block SHALL operate normally, with InReady=1.

Verification
REQ-035 Bench SHALL cover: reset, then InValid=1, InRa=1, InRb=2, InOp=3'b000, with registers 1 and 2 never written -> next cycle OutValid=1, InputA=0, InputB=0, OP=0.
REQ-036 Bench SHALL cover: write R3=8'h5A, then issue Ra=3 with InImmSel=1 and InImm=8'h0F -> InputA=8'h5A, InputB=8'h0F.
REQ-037 Bench SHALL cover: in the same cycle, WbEn=1 with WbAddr=4 and WbData=8'hC3, and an accept with Ra=4 and Rb=4 -> InputA=InputB=8'hC3.
REQ-038 Bench SHALL cover: hold OutReady=0 for 3 cycles with InValid=1 -> InReady=0, outputs stable, and no second bundle lost; then OutReady=1 -> the next bundle appears one cycle later.
REQ-039 Bench SHALL cover: a held bundle with InputA=8'h11 from R5, then writeback R5=8'h22 during the stall -> InputA stays 8'h11.
REQ-040 Bench SHALL cover: assert Reset_n=0 mid-stall with OutValid=1 -> OutValid=0 immediately, and all registers read 0 after reset releases.
